dafx_axi_slave: RTL and testbench
=================================

# dafx_axi_slave

AXI4-Lite slave that implements the DAFX control/status register map: it decodes the 16-bit byte addresses 0x0000–0x0080, holds the configuration registers for the mixer and oscillator 0, exposes the circuit-amplitude and mixer-output status values read-only, and generates single-cycle clear commands. It sits between the PS AXI interconnect and the DAFX audio datapath. It is the only place where the register map is turned into hardware.

## Interface
Parameters:
- AXI_DATA_WIDTH_P, 64, data bus width; registers are 8-byte aligned.
- AXI_ADDR_WIDTH_P, 16, address width.
- HW_VERSION_P, 64'h0000_0000_0001_0000, value returned at HARDWARE_VERSION (0x0000).

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- awaddr/awvalid/awready  in/in/out  16/1/1  write address channel
- wdata/wstrb/wvalid/wready  in/in/in/out  64/8/1/1  write data channel
- bresp/bvalid/bready  out/out/in  2/1/1  write response
- araddr/arvalid/arready  in/in/out  16/1/1  read address channel
- rdata/rresp/rvalid/rready  out/out/out/in  64/2/1/1  read data channel
- cr_mix_output_gain, cr_mix_channel_gain_0..2  out  64 each  mixer gains (RW)
- cr_osc0_waveform_select  out  2  (RW, bits [1:0])
- cr_osc0_frequency, cr_osc0_duty_cycle  out  64 each  (RW)
- sr_cir_min_adc_amplitude, sr_cir_max_adc_amplitude, sr_cir_min_dac_amplitude, sr_cir_max_dac_amplitude  in  64 each  status (RO)
- sr_mix_out_left, sr_mix_out_right  in  64 each  status (RO)
- cmd_clear_adc_amplitude, cmd_clear_irq_0, cmd_clear_irq_1  out  1 each  one-cycle pulses

## Operation
- Decode on awaddr/araddr[15:3]; bits [2:0] ignored.
- RW: 0x08 output gain, 0x10/0x18/0x20 channel gains, 0x28 waveform select, 0x30 frequency, 0x38 duty cycle. Per-byte wstrb honoured. Waveform select stores wdata[1:0] only when wstrb[0]=1.
- RO: 0x00 version, 0x40–0x58 the four sr_cir_* values, 0x78/0x80 sr_mix_out_left/right. Writes return SLVERR (2'b10) and change nothing.
- Command: 0x60 clear ADC amplitude, 0x68 clear IRQ 0, 0x70 clear IRQ 1. A write with any wstrb bit set pulses the matching cmd_* for exactly one cycle, regardless of wdata. A write with wstrb=0 is OKAY and does not pulse. Reads return 0, OKAY.
- Address ≥ 0x0088 (DAFX_HIGH_ADDRESS): read → rdata 0, SLVERR; write → no effect, SLVERR.
- Write FSM, states: W_IDLE (capturing AW and/or W), W_COMMIT, W_RESP.
  - AW and W are accepted independently and in either order. Each ready drops once its channel is captured.
  - When both are captured: go to W_COMMIT for one cycle (register update, cmd pulse), then W_RESP with bvalid=1 until bready, then W_IDLE.
- Read FSM, states: R_IDLE (arready=1), R_DATA (rvalid=1, rdata/rresp held stable until rready).
- A read and a write to the same address committing in the same cycle: the read returns the pre-write value.
- Reset values: every cr_* = 0, cmd_* = 0, all ready/valid outputs = 0, bresp/rresp = 0, rdata = 0. The FSMs return to IDLE.
- rst mid-transaction: in-flight transactions are discarded and no response is issued. awready/wready/arready go to 1 the cycle after rst deasserts.

## Timing
- Write: last of AW/W handshake in cycle N → commit in N+1 (cr_* visible and cmd_* high in N+2 registered output, i.e. one cycle after commit) → bvalid high from N+2.
- Minimum write spacing: 3 cycles with bready tied high.
- Read: AR handshake in cycle N → rvalid and rdata in N+1. sr_* are sampled in cycle N.
- Minimum read spacing: 2 cycles with rready tied high.
- Read and write paths are fully independent and may be active in the same cycle.
- All outputs are registered. There are no combinational paths from AXI inputs to AXI outputs.

## Test plan
- Reset: drive rst for 2 cycles with all valids high → all cr_*/cmd_*/valid = 0. Readies = 1 the cycle after release.
- Write 0x30 wdata 64'h0000_0000_0012_3456, wstrb 8'hFF, W sent 3 cycles before AW → bresp OKAY. cr_osc0_frequency = 0x123456. A read of 0x30 returns the same value.
- Write 0x08 wdata all-ones, wstrb 8'h0F over a prior value of 0 → cr_mix_output_gain = 64'h0000_0000_FFFF_FFFF.
- Write 0x68 (any data, wstrb 8'h01) → cmd_clear_irq_0 high for exactly 1 cycle, the other cmds stay 0. A read of 0x68 returns 0.
- Set sr_cir_max_dac_amplitude = 0x7FFF, read 0x58 → rdata 0x7FFF, OKAY. Write 0x58 → SLVERR, sr path unchanged.
- Read 0x0088 and write 0x0100 → both SLVERR, rdata 0, no cr_* change. Back-to-back reads with rready low for 5 cycles → rdata held stable and arready = 0 throughout.

Source files
------------

// File: rtl/dafx_axi_slave.sv
// dafx_axi_slave: AXI4-Lite slave for the DAFX control/status register map
module dafx_axi_slave #(
  parameter int AXI_DATA_WIDTH_P = 64,
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter logic [AXI_DATA_WIDTH_P-1:0] HW_VERSION_P = 64'h0000_0000_0001_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic [AXI_ADDR_WIDTH_P-1:0] awaddr,
  input  logic awvalid,
  output logic awready,
  input  logic [AXI_DATA_WIDTH_P-1:0] wdata,
  input  logic [AXI_DATA_WIDTH_P/8-1:0] wstrb,
  input  logic wvalid,
  output logic wready,
  output logic [1:0] bresp,
  output logic bvalid,
  input  logic bready,
  input  logic [AXI_ADDR_WIDTH_P-1:0] araddr,
  input  logic arvalid,
  output logic arready,
  output logic [AXI_DATA_WIDTH_P-1:0] rdata,
  output logic [1:0] rresp,
  output logic rvalid,
  input  logic rready,
  output logic [AXI_DATA_WIDTH_P-1:0] cr_mix_output_gain,
  output logic [AXI_DATA_WIDTH_P-1:0] cr_mix_channel_gain_0,
  output logic [AXI_DATA_WIDTH_P-1:0] cr_mix_channel_gain_1,
  output logic [AXI_DATA_WIDTH_P-1:0] cr_mix_channel_gain_2,
  output logic [1:0] cr_osc0_waveform_select,
  output logic [AXI_DATA_WIDTH_P-1:0] cr_osc0_frequency,
  output logic [AXI_DATA_WIDTH_P-1:0] cr_osc0_duty_cycle,
  input  logic [AXI_DATA_WIDTH_P-1:0] sr_cir_min_adc_amplitude,
  input  logic [AXI_DATA_WIDTH_P-1:0] sr_cir_max_adc_amplitude,
  input  logic [AXI_DATA_WIDTH_P-1:0] sr_cir_min_dac_amplitude,
  input  logic [AXI_DATA_WIDTH_P-1:0] sr_cir_max_dac_amplitude,
  input  logic [AXI_DATA_WIDTH_P-1:0] sr_mix_out_left,
  input  logic [AXI_DATA_WIDTH_P-1:0] sr_mix_out_right,
  output logic cmd_clear_adc_amplitude,
  output logic cmd_clear_irq_0,
  output logic cmd_clear_irq_1
);
  localparam int DW = AXI_DATA_WIDTH_P;
  localparam int SW = DW / 8;
  localparam int AW = AXI_ADDR_WIDTH_P;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic aw_hs, w_hs, ar_hs, aw_got, w_got, aw_got_n, w_got_n, aw_got_d, w_got_d;
  logic commit, wr_ok, rd_ok, awready_d, wready_d, arready_d, bvalid_d, rvalid_d;
  logic [1:0] bresp_d;
  logic [AW-4:0] w_idx;
  logic [DW-1:0] w_data, w_mask, rd_val;
  logic [SW-1:0] w_strb;
  int wi, ri;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{awaddr[2:0], araddr[2:0]};
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign aw_got_n = aw_got | aw_hs;
  assign w_got_n = w_got | w_hs;
  assign wi = int'(w_idx);
  assign ri = int'(araddr[AW-1:3]);

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = (w_state == W_COMMIT) ? W_RESP :
             (w_state == W_RESP) ? (bready ? W_IDLE : W_RESP) :
             (aw_got_n && w_got_n) ? W_COMMIT : W_IDLE;
    r_next = (r_state == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE) : (rready ? R_IDLE : R_DATA);
  end

  always_comb begin
    commit = (w_state == W_COMMIT);
    wr_ok = (wi >= 1 && wi <= 7) || (wi >= 12 && wi <= 14);
    rd_ok = (ri <= 16);
    aw_got_d = (w_state == W_RESP && bready) ? 1'b0 : aw_got_n;
    w_got_d = (w_state == W_RESP && bready) ? 1'b0 : w_got_n;
    awready_d = (w_next == W_IDLE) && !aw_got_d;
    wready_d = (w_next == W_IDLE) && !w_got_d;
    bvalid_d = (w_next == W_RESP);
    bresp_d = commit ? (wr_ok ? OKAY : SLVERR) : bresp;
    arready_d = (r_next == R_IDLE);
    rvalid_d = (r_next == R_DATA);
    w_mask = '0;
    for (int i = 0; i < SW; i++) w_mask[8*i +: 8] = {8{w_strb[i]}};
  end

  // Command and unused slots read as zero; out-of-range reads also zero with SLVERR
  always_comb begin
    rd_val = '0;
    case (ri)
      0: rd_val = HW_VERSION_P;
      1: rd_val = cr_mix_output_gain;
      2: rd_val = cr_mix_channel_gain_0;
      3: rd_val = cr_mix_channel_gain_1;
      4: rd_val = cr_mix_channel_gain_2;
      5: rd_val = {{(DW-2){1'b0}}, cr_osc0_waveform_select};
      6: rd_val = cr_osc0_frequency;
      7: rd_val = cr_osc0_duty_cycle;
      8: rd_val = sr_cir_min_adc_amplitude;
      9: rd_val = sr_cir_max_adc_amplitude;
      10: rd_val = sr_cir_min_dac_amplitude;
      11: rd_val = sr_cir_max_dac_amplitude;
      15: rd_val = sr_mix_out_left;
      16: rd_val = sr_mix_out_right;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0;
      w_got <= 1'b0;
      awready <= 1'b0;
      wready <= 1'b0;
      arready <= 1'b0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      bresp <= OKAY;
      rresp <= OKAY;
      rdata <= '0;
      w_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      cr_mix_output_gain <= '0;
      cr_mix_channel_gain_0 <= '0;
      cr_mix_channel_gain_1 <= '0;
      cr_mix_channel_gain_2 <= '0;
      cr_osc0_waveform_select <= '0;
      cr_osc0_frequency <= '0;
      cr_osc0_duty_cycle <= '0;
      cmd_clear_adc_amplitude <= 1'b0;
      cmd_clear_irq_0 <= 1'b0;
      cmd_clear_irq_1 <= 1'b0;
    end else begin
      aw_got <= aw_got_d;
      w_got <= w_got_d;
      awready <= awready_d;
      wready <= wready_d;
      arready <= arready_d;
      bvalid <= bvalid_d;
      rvalid <= rvalid_d;
      bresp <= bresp_d;
      if (aw_hs) w_idx <= awaddr[AW-1:3];
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (ar_hs) begin
        rdata <= rd_val;
        rresp <= rd_ok ? OKAY : SLVERR;
      end
      if (commit && wi == 1) cr_mix_output_gain <= merge(cr_mix_output_gain, w_data, w_mask);
      if (commit && wi == 2) cr_mix_channel_gain_0 <= merge(cr_mix_channel_gain_0, w_data, w_mask);
      if (commit && wi == 3) cr_mix_channel_gain_1 <= merge(cr_mix_channel_gain_1, w_data, w_mask);
      if (commit && wi == 4) cr_mix_channel_gain_2 <= merge(cr_mix_channel_gain_2, w_data, w_mask);
      if (commit && wi == 5 && w_strb[0]) cr_osc0_waveform_select <= w_data[1:0];
      if (commit && wi == 6) cr_osc0_frequency <= merge(cr_osc0_frequency, w_data, w_mask);
      if (commit && wi == 7) cr_osc0_duty_cycle <= merge(cr_osc0_duty_cycle, w_data, w_mask);
      cmd_clear_adc_amplitude <= commit && wi == 12 && |w_strb;
      cmd_clear_irq_0 <= commit && wi == 13 && |w_strb;
      cmd_clear_irq_1 <= commit && wi == 14 && |w_strb;
    end
  end
endmodule

// File: tb/tb_dafx_axi_slave.sv
// tb_dafx_axi_slave: directed register-map tests for dafx_axi_slave
module tb_dafx_axi_slave;
  logic clk = 0, rst = 1;
  logic [15:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [7:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [63:0] gain, ch0, ch1, ch2, freq, duty;
  logic [1:0] wave;
  logic [63:0] sr_min_adc, sr_max_adc, sr_min_dac, sr_max_dac, sr_left, sr_right;
  logic c_adc, c_irq0, c_irq1;
  int vecs = 0, errs = 0;
  int n_adc = 0, n_irq0 = 0, n_irq1 = 0;

  always #5 clk = ~clk;

  dafx_axi_slave dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cr_mix_output_gain(gain), .cr_mix_channel_gain_0(ch0),
    .cr_mix_channel_gain_1(ch1), .cr_mix_channel_gain_2(ch2),
    .cr_osc0_waveform_select(wave), .cr_osc0_frequency(freq), .cr_osc0_duty_cycle(duty),
    .sr_cir_min_adc_amplitude(sr_min_adc), .sr_cir_max_adc_amplitude(sr_max_adc),
    .sr_cir_min_dac_amplitude(sr_min_dac), .sr_cir_max_dac_amplitude(sr_max_dac),
    .sr_mix_out_left(sr_left), .sr_mix_out_right(sr_right),
    .cmd_clear_adc_amplitude(c_adc), .cmd_clear_irq_0(c_irq0), .cmd_clear_irq_1(c_irq1)
  );

  always @(negedge clk) begin
    if (c_adc) n_adc++;
    if (c_irq0) n_irq0++;
    if (c_irq1) n_irq1++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int lead, output logic [1:0] resp, output int lat);
    int n;
    wdata = d; wstrb = s; wvalid = 1; n = 0;
    while (!wready && n < 50) begin step(); n++; end
    step();
    wvalid = 0;
    repeat (lead) step();
    awaddr = a; awvalid = 1; n = 0;
    while (!awready && n < 50) begin step(); n++; end
    step();
    awvalid = 0; lat = 0;
    while (!bvalid && lat < 50) begin step(); lat++; end
    if (lat >= 50) begin
      vecs++; errs++;
      $display("FAIL write_timeout addr=%h got no bvalid, need bvalid=1", a);
    end
    resp = bresp;
    step();
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [63:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1; n = 0;
    while (!arready && n < 50) begin step(); n++; end
    step();
    arvalid = 0; n = 0;
    while (!rvalid && n < 50) begin step(); n++; end
    if (n >= 50) begin
      vecs++; errs++;
      $display("FAIL read_timeout addr=%h got no rvalid, need rvalid=1", a);
    end
    d = rdata; resp = rresp;
    step();
  endtask

  task automatic test_reset();
    awaddr = 16'h0008; araddr = 16'h0000; wdata = '1; wstrb = 8'hFF;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    rst = 1;
    repeat (2) step();
    vecs++;
    if ({gain, ch0, ch1, ch2, wave, freq, duty} !== '0) begin
      errs++; $display("FAIL reset_cr got nonzero cr_* need 0");
    end
    vecs++;
    if ({c_adc, c_irq0, c_irq1, bvalid, rvalid, awready, wready, arready} !== 8'b0) begin
      errs++;
      $display("FAIL reset_ctl got %b need 00000000", {c_adc, c_irq0, c_irq1, bvalid, rvalid, awready, wready, arready});
    end
    vecs++;
    if ({bresp, rresp, rdata} !== '0) begin
      errs++; $display("FAIL reset_resp got bresp=%b rresp=%b rdata=%h need 0", bresp, rresp, rdata);
    end
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    step();
    vecs++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      errs++; $display("FAIL reset_release got %b need 11100", {awready, wready, arready, bvalid, rvalid});
    end
  endtask

  task automatic test_rw_frequency();
    logic [1:0] r; logic [63:0] d; int lat;
    axi_write(16'h0030, 64'h0000_0000_0012_3456, 8'hFF, 3, r, lat);
    vecs++;
    if (r !== 2'b00) begin errs++; $display("FAIL freq_bresp got %b need 00", r); end
    vecs++;
    if (lat !== 1) begin errs++; $display("FAIL freq_latency got %0d need 1", lat); end
    vecs++;
    if (freq !== 64'h123456) begin errs++; $display("FAIL freq_value got %h need 123456", freq); end
    axi_read(16'h0030, d, r);
    vecs++;
    if (d !== 64'h123456 || r !== 2'b00) begin
      errs++; $display("FAIL freq_readback got %h/%b need 123456/00", d, r);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] r; int lat;
    axi_write(16'h0008, '1, 8'h0F, 0, r, lat);
    vecs++;
    if (gain !== 64'h0000_0000_FFFF_FFFF) begin errs++; $display("FAIL gain_lo got %h need 00000000ffffffff", gain); end
    axi_write(16'h000C, 64'h1122_3344_5566_7788, 8'hF0, 1, r, lat);
    vecs++;
    if (gain !== 64'h1122_3344_FFFF_FFFF) begin errs++; $display("FAIL gain_hi got %h need 11223344ffffffff", gain); end
    axi_write(16'h0028, 64'h7, 8'h01, 0, r, lat);
    vecs++;
    if (wave !== 2'b11) begin errs++; $display("FAIL wave_set got %b need 11", wave); end
    axi_write(16'h0028, 64'h0, 8'hFE, 0, r, lat);
    vecs++;
    if (wave !== 2'b11 || r !== 2'b00) begin errs++; $display("FAIL wave_nostrb got %b/%b need 11/00", wave, r); end
  endtask

  task automatic test_commands();
    logic [1:0] r; logic [63:0] d; int lat;
    n_adc = 0; n_irq0 = 0; n_irq1 = 0;
    axi_write(16'h0068, 64'hDEAD, 8'h01, 0, r, lat);
    repeat (3) step();
    vecs++;
    if (n_irq0 !== 1 || n_adc !== 0 || n_irq1 !== 0 || r !== 2'b00) begin
      errs++; $display("FAIL cmd_irq0 got adc=%0d irq0=%0d irq1=%0d resp=%b need 0/1/0/00", n_adc, n_irq0, n_irq1, r);
    end
    axi_read(16'h0068, d, r);
    vecs++;
    if (d !== 64'h0 || r !== 2'b00) begin errs++; $display("FAIL cmd_read got %h/%b need 0/00", d, r); end
    axi_write(16'h0060, '1, 8'h00, 0, r, lat);
    axi_write(16'h0070, 64'h0, 8'h80, 0, r, lat);
    repeat (3) step();
    vecs++;
    if (n_adc !== 0 || n_irq1 !== 1 || n_irq0 !== 1) begin
      errs++; $display("FAIL cmd_strb got adc=%0d irq0=%0d irq1=%0d need 0/1/1", n_adc, n_irq0, n_irq1);
    end
  endtask

  task automatic test_status();
    logic [1:0] r; logic [63:0] d; int lat; logic [449:0] snap;
    sr_max_dac = 64'h7FFF;
    axi_read(16'h0058, d, r);
    vecs++;
    if (d !== 64'h7FFF || r !== 2'b00) begin errs++; $display("FAIL sr_read got %h/%b need 7fff/00", d, r); end
    axi_read(16'h0080, d, r);
    vecs++;
    if (d !== 64'hABCD_0000_0000_1234 || r !== 2'b00) begin errs++; $display("FAIL sr_right got %h/%b need abcd000000001234/00", d, r); end
    snap = {gain, ch0, ch1, ch2, wave, freq, duty};
    axi_write(16'h0058, 64'h1234, 8'hFF, 0, r, lat);
    vecs++;
    if (r !== 2'b10) begin errs++; $display("FAIL sr_write_resp got %b need 10", r); end
    axi_read(16'h0058, d, r);
    vecs++;
    if (d !== 64'h7FFF || {gain, ch0, ch1, ch2, wave, freq, duty} !== snap) begin
      errs++; $display("FAIL sr_write_effect got %h need 7fff and cr unchanged", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [63:0] d; int lat; logic [449:0] snap;
    snap = {gain, ch0, ch1, ch2, wave, freq, duty};
    axi_read(16'h0088, d, r);
    vecs++;
    if (d !== 64'h0 || r !== 2'b10) begin errs++; $display("FAIL oor_read got %h/%b need 0/10", d, r); end
    axi_write(16'h0100, '1, 8'hFF, 0, r, lat);
    vecs++;
    if (r !== 2'b10 || {gain, ch0, ch1, ch2, wave, freq, duty} !== snap) begin
      errs++; $display("FAIL oor_write got resp %b need 10 and cr unchanged", r);
    end
  endtask

  task automatic test_back_to_back();
    rready = 0; araddr = 16'h0058; arvalid = 1;
    step();
    araddr = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++;
      if (rdata !== 64'h7FFF || rvalid !== 1'b1 || arready !== 1'b0) begin
        errs++; $display("FAIL hold_%0d got rdata=%h rvalid=%b arready=%b need 7fff/1/0", i, rdata, rvalid, arready);
      end
    end
    rready = 1;
    step();
    step();
    arvalid = 0;
    vecs++;
    if (rdata !== 64'h0000_0000_0001_0000 || rvalid !== 1'b1 || rresp !== 2'b00) begin
      errs++; $display("FAIL b2b_version got %h/%b/%b need 0000000000010000/1/00", rdata, rvalid, rresp);
    end
    step();
  endtask

  initial begin
    sr_min_adc = 64'h11; sr_max_adc = 64'h22; sr_min_dac = 64'h33; sr_max_dac = 64'h0;
    sr_left = 64'h55; sr_right = 64'hABCD_0000_0000_1234;
    test_reset();
    test_rw_frequency();
    test_strobes();
    test_commands();
    test_status();
    test_out_of_range();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
